// File: rtl/lanes_frame_merger.sv
// lanes_frame_merger
//   Merges LANE_COUNT AXI-Stream input lanes into a single output stream, one
//   whole frame at a time. Arbitration is either round-robin or fixed priority
//   (lowest index wins). An optional header word (lane index + 1) can precede
//   each frame. A lane that goes quiet for TIMEOUT_CYCLES mid-frame has its
//   frame closed with an all-ones abort word.
//
// Ports
//   clk_core, clk_core_resn          clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tlast/tready per-lane input streams (lane i data at
//                                    bits [i*DATA_WIDTH +: DATA_WIDTH])
//   m_axis_tdata/tvalid/tlast/tready merged output stream
//   m_axis_tdest                     source lane of the current output beat
//   cfg_lane_enable                  lanes allowed to win arbitration
//   cfg_priority_mode                0 round-robin, 1 fixed (lowest index)
//   cfg_header_enable                emit a header word before each frame
//   stat_frame_count                 32-bit completed-frame counter per lane
//   stat_timeout_count               16-bit saturating abort counter per lane
//   status_busy, status_grant        FSM not idle, currently granted lane
module lanes_frame_merger #(
    parameter int LANE_COUNT     = 3,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                             clk_core,
    input  logic                             clk_core_resn,
    input  logic [LANE_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [LANE_COUNT-1:0]            s_axis_tvalid,
    input  logic [LANE_COUNT-1:0]            s_axis_tlast,
    output logic [LANE_COUNT-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic                             m_axis_tvalid,
    output logic                             m_axis_tlast,
    input  logic                             m_axis_tready,
    output logic [7:0]                       m_axis_tdest,
    input  logic [LANE_COUNT-1:0]            cfg_lane_enable,
    input  logic                             cfg_priority_mode,
    input  logic                             cfg_header_enable,
    output logic [LANE_COUNT*32-1:0]         stat_frame_count,
    output logic [LANE_COUNT*16-1:0]         stat_timeout_count,
    output logic                             status_busy,
    output logic [7:0]                       status_grant
);

    localparam int GW = (LANE_COUNT > 1) ? $clog2(LANE_COUNT) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA,
        ABORT
    } state_t;

    state_t                      state_q, state_d;
    logic [GW-1:0]               grant_q, grant_d;
    logic [GW-1:0]               last_grant_q, last_grant_d;
    logic [TW-1:0]               idle_cnt_q, idle_cnt_d;
    logic [LANE_COUNT-1:0][31:0] frame_cnt_q, frame_cnt_d;
    logic [LANE_COUNT-1:0][15:0] timeout_cnt_q, timeout_cnt_d;

    logic [LANE_COUNT-1:0]       request;
    logic [GW-1:0]               winner;
    logic                        sel_valid;
    logic                        sel_last;
    logic [DATA_WIDTH-1:0]       sel_data;
    logic [7:0]                  grant_ext;

    assign grant_ext          = 8'(grant_q);
    assign status_busy        = (state_q != IDLE);
    assign status_grant       = grant_ext;
    assign stat_frame_count   = frame_cnt_q;
    assign stat_timeout_count = timeout_cnt_q;

    // Mux the granted lane's stream onto internal select signals.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < LANE_COUNT; i++) begin
            if (grant_q == GW'(i)) begin
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Arbiter. The first pass finds the lowest requester overall, which is the
    // fixed-priority answer and also the round-robin wrap-around answer. In
    // round-robin mode a second pass overrides it with the lowest requester
    // above last_grant, if there is one.
    always_comb begin
        request = s_axis_tvalid & cfg_lane_enable;
        winner  = '0;
        for (int i = LANE_COUNT - 1; i >= 0; i--) begin
            if (request[i]) begin
                winner = GW'(i);
            end
        end
        if (!cfg_priority_mode) begin
            for (int i = LANE_COUNT - 1; i >= 0; i--) begin
                if (request[i] && (GW'(i) > last_grant_q)) begin
                    winner = GW'(i);
                end
            end
        end
    end

    // Next-state, counters and output drive.
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_grant_d   = last_grant_q;
        idle_cnt_d     = idle_cnt_q;
        frame_cnt_d    = frame_cnt_q;
        timeout_cnt_d  = timeout_cnt_q;
        m_axis_tvalid  = 1'b0;
        m_axis_tlast   = 1'b0;
        m_axis_tdata   = '0;
        m_axis_tdest   = '0;
        s_axis_tready  = '0;

        case (state_q)
            IDLE: begin
                if (|request) begin
                    grant_d      = winner;
                    last_grant_d = winner;
                    idle_cnt_d   = '0;
                    state_d      = cfg_header_enable ? HEADER : DATA;
                end
            end

            HEADER: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = DATA_WIDTH'(grant_q) + DATA_WIDTH'(1);
                m_axis_tdest  = grant_ext;
                if (m_axis_tready) begin
                    state_d = DATA;
                end
            end

            DATA: begin
                m_axis_tvalid = sel_valid;
                m_axis_tlast  = sel_last;
                m_axis_tdata  = sel_data;
                m_axis_tdest  = grant_ext;
                for (int i = 0; i < LANE_COUNT; i++) begin
                    if (grant_q == GW'(i)) begin
                        s_axis_tready[i] = m_axis_tready;
                    end
                end
                // A valid-but-stalled beat is activity, so backpressure
                // keeps the idle counter cleared.
                if (sel_valid) begin
                    idle_cnt_d = '0;
                    if (sel_last && m_axis_tready) begin
                        for (int i = 0; i < LANE_COUNT; i++) begin
                            if (grant_q == GW'(i)) begin
                                frame_cnt_d[i] = frame_cnt_q[i] + 32'd1;
                            end
                        end
                        state_d = IDLE;
                    end
                end else if (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    idle_cnt_d = '0;
                    state_d    = ABORT;
                end else begin
                    idle_cnt_d = idle_cnt_q + TW'(1);
                end
            end

            ABORT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tdata  = '1;
                m_axis_tdest  = grant_ext;
                if (m_axis_tready) begin
                    for (int i = 0; i < LANE_COUNT; i++) begin
                        if ((grant_q == GW'(i)) && (timeout_cnt_q[i] != 16'hFFFF)) begin
                            timeout_cnt_d[i] = timeout_cnt_q[i] + 16'd1;
                        end
                    end
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and counter registers; reset drops any frame in flight.
    always_ff @(posedge clk_core or negedge clk_core_resn) begin
        if (!clk_core_resn) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            last_grant_q  <= GW'(LANE_COUNT - 1);
            idle_cnt_q    <= '0;
            frame_cnt_q   <= '0;
            timeout_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            idle_cnt_q    <= idle_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

endmodule

// File: tb/tb_lanes_frame_merger.sv
// tb_lanes_frame_merger
//   Drives per-lane frame buffers into lanes_frame_merger and checks the merged
//   stream frame by frame: headers, per-lane data order, frame contiguity,
//   abort words, arbitration order and the statistics counters.
module tb_lanes_frame_merger;

    localparam int LANES = 3;
    localparam int DW    = 8;
    localparam int TMO   = 1024;

    logic                  clk_core;
    logic                  clk_core_resn;
    logic [LANES*DW-1:0]   s_axis_tdata;
    logic [LANES-1:0]      s_axis_tvalid;
    logic [LANES-1:0]      s_axis_tlast;
    logic [LANES-1:0]      s_axis_tready;
    logic [DW-1:0]         m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tlast;
    logic                  m_axis_tready;
    logic [7:0]            m_axis_tdest;
    logic [LANES-1:0]      cfg_lane_enable;
    logic                  cfg_priority_mode;
    logic                  cfg_header_enable;
    logic [LANES*32-1:0]   stat_frame_count;
    logic [LANES*16-1:0]   stat_timeout_count;
    logic                  status_busy;
    logic [7:0]            status_grant;

    lanes_frame_merger #(
        .LANE_COUNT     (LANES),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_core           (clk_core),
        .clk_core_resn      (clk_core_resn),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tlast       (s_axis_tlast),
        .s_axis_tready      (s_axis_tready),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tlast       (m_axis_tlast),
        .m_axis_tready      (m_axis_tready),
        .m_axis_tdest       (m_axis_tdest),
        .cfg_lane_enable    (cfg_lane_enable),
        .cfg_priority_mode  (cfg_priority_mode),
        .cfg_header_enable  (cfg_header_enable),
        .stat_frame_count   (stat_frame_count),
        .stat_timeout_count (stat_timeout_count),
        .status_busy        (status_busy),
        .status_grant       (status_grant)
    );

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    int checks_total  = 0;
    int checks_passed = 0;

    // Each lane's offered beats {last, data}; head = next beat to offer,
    // out_ptr = next beat expected on the merged output.
    logic [8:0] lane_buf [LANES][64];
    int         lane_head [LANES];
    int         lane_tail [LANES];
    int         out_ptr [LANES];
    int         exp_frames [LANES];
    bit         lane_acc [LANES];
    int         cur_lane;
    int         frame_log [$];
    int         aborts_seen;
    int         abort_lane;
    int         beats_out;
    int         cycle_no;
    int         last_data_cycle;
    int         abort_cycle;
    int         gap_pct;
    int         ready_mode;

    // Counts one comparison and reports it when it does not hold.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] statFrames(input int i);
        return stat_frame_count[i*32 +: 32];
    endfunction

    function automatic logic [31:0] statTimeouts(input int i);
        return 32'(stat_timeout_count[i*16 +: 16]);
    endfunction

    task automatic clearBench();
        s_axis_tdata      = '0;
        s_axis_tvalid     = '0;
        s_axis_tlast      = '0;
        m_axis_tready     = 1'b1;
        cfg_lane_enable   = '1;
        cfg_priority_mode = 1'b0;
        cfg_header_enable = 1'b1;
        gap_pct           = 0;
        ready_mode        = 0;
        cur_lane          = -1;
        aborts_seen       = 0;
        abort_lane        = -1;
        beats_out         = 0;
        cycle_no          = 0;
        last_data_cycle   = 0;
        abort_cycle       = 0;
        frame_log.delete();
        for (int i = 0; i < LANES; i++) begin
            lane_head[i]  = 0;
            lane_tail[i]  = 0;
            out_ptr[i]    = 0;
            exp_frames[i] = 0;
            lane_acc[i]   = 1'b0;
            for (int k = 0; k < 64; k++) lane_buf[i][k] = '0;
        end
    endtask

    // Reset the DUT and the bench model together, checking the reset state.
    task automatic applyReset();
        @(negedge clk_core);
        clk_core_resn = 1'b0;
        clearBench();
        #1;
        checkOutput("rst_busy",   32'(status_busy), 32'd0);
        checkOutput("rst_grant",  32'(status_grant), 32'd0);
        checkOutput("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("rst_sready", 32'(s_axis_tready), 32'd0);
        checkOutput("rst_stats",  32'(|{stat_frame_count, stat_timeout_count}), 32'd0);
        repeat (2) @(negedge clk_core);
        clk_core_resn = 1'b1;
    endtask

    task automatic addBeat(input int lane, input logic [7:0] data, input logic last);
        lane_buf[lane][lane_tail[lane]] = {last, data};
        lane_tail[lane]++;
    endtask

    task automatic addFrame(input int lane, input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) addBeat(lane, base + 8'(k), k == n - 1);
        exp_frames[lane]++;
    endtask

    task automatic addRandomFrame(input int lane, input int n);
        for (int k = 0; k < n; k++) addBeat(lane, 8'($urandom_range(254)), k == n - 1);
        exp_frames[lane]++;
    endtask

    // Reference model of the merged stream: a frame is an optional header
    // (lane+1) followed by the granted lane's beats in order up to its tlast,
    // or cut short by a single all-ones abort word.
    task automatic monitorBeat(input logic [7:0] d, input logic l, input logic [7:0] dest);
        logic [8:0] exp_beat;
        beats_out++;
        if (cur_lane < 0) begin
            frame_log.push_back(int'(dest));
            if (dest >= 8'(LANES)) begin
                checkOutput("dest_range", 32'(dest), 32'(LANES - 1));
                return;
            end
            cur_lane = int'(dest);
            if (cfg_header_enable) begin
                checkOutput("header_data", 32'(d), 32'(dest) + 32'd1);
                checkOutput("header_last", 32'(l), 32'd0);
                return;
            end
        end
        checkOutput("beat_dest", 32'(dest), 32'(cur_lane));
        if (d == 8'hFF) begin
            aborts_seen++;
            abort_lane  = cur_lane;
            abort_cycle = cycle_no;
            checkOutput("abort_last", 32'(l), 32'd1);
            cur_lane = -1;
            return;
        end
        if (out_ptr[cur_lane] >= lane_tail[cur_lane]) begin
            checkOutput("extra_beat", 32'(out_ptr[cur_lane]), 32'(lane_tail[cur_lane] - 1));
            cur_lane = -1;
            return;
        end
        exp_beat = lane_buf[cur_lane][out_ptr[cur_lane]];
        checkOutput("beat_data", 32'(d), 32'(exp_beat[7:0]));
        checkOutput("beat_last", 32'(l), 32'(exp_beat[8]));
        out_ptr[cur_lane]++;
        last_data_cycle = cycle_no;
        if (l) cur_lane = -1;
    endtask

    // Advance lanes whose beat was accepted and present the next beats.
    task automatic applyStimulus();
        logic [8:0] b;
        for (int i = 0; i < LANES; i++) begin
            if (lane_acc[i]) lane_head[i]++;
            lane_acc[i] = 1'b0;
            if (lane_head[i] < lane_tail[i] && $urandom_range(99) >= gap_pct) begin
                b = lane_buf[i][lane_head[i]];
                s_axis_tvalid[i]         = 1'b1;
                s_axis_tlast[i]          = b[8];
                s_axis_tdata[i*DW +: DW] = b[7:0];
            end else begin
                s_axis_tvalid[i]         = 1'b0;
                s_axis_tlast[i]          = 1'b0;
                s_axis_tdata[i*DW +: DW] = '0;
            end
        end
        case (ready_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ($urandom_range(99) < 70);
            default: m_axis_tready = 1'b0;
        endcase
    endtask

    task automatic runCycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk_core);
            cycle_no++;
            for (int i = 0; i < LANES; i++) lane_acc[i] = s_axis_tvalid[i] && s_axis_tready[i];
            if (m_axis_tvalid && m_axis_tready) monitorBeat(m_axis_tdata, m_axis_tlast, m_axis_tdest);
            @(posedge clk_core);
            #1;
            applyStimulus();
        end
    endtask

    task automatic drain(input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            runCycles(1);
            done = (cur_lane < 0);
            for (int i = 0; i < LANES; i++) if (out_ptr[i] != lane_tail[i]) done = 1'b0;
        end
        checkOutput("drain_done", 32'(done), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cnt;
        clk_core_resn = 1'b0;
        clearBench();

        // Three lanes at once, round-robin with headers.
        applyReset();
        for (int l = 0; l < LANES; l++) addFrame(l, 3, 8'(l * 16 + 1));
        runCycles(30);
        checkOutput("rr_beats", 32'(beats_out), 32'd12);
        checkOutput("rr_frames", 32'(frame_log.size()), 32'd3);
        for (int l = 0; l < LANES; l++) begin
            if (frame_log.size() > l) checkOutput("rr_order", 32'(frame_log[l]), 32'(l));
            checkOutput("rr_stat", statFrames(l), 32'd1);
        end

        // Fixed priority: lane 0 keeps requesting, lane 2 starves.
        applyReset();
        cfg_priority_mode = 1'b1;
        cfg_header_enable = 1'b0;
        for (int f = 0; f < 20; f++) addFrame(0, 2, 8'(f * 2));
        for (int f = 0; f < 3; f++) addFrame(2, 2, 8'(8'hA0 + f * 2));
        runCycles(40);
        cnt = 0;
        foreach (frame_log[k]) if (frame_log[k] != 0) cnt++;
        checkOutput("fix_starve", 32'(cnt), 32'd0);
        checkOutput("fix_progress", 32'(frame_log.size() >= 10), 32'd1);
        checkOutput("fix_stat2", statFrames(2), 32'd0);
        checkOutput("fix_stat0", statFrames(0), 32'(out_ptr[0] / 2));

        // Lane 1 stalls mid-frame long enough to be aborted.
        applyReset();
        addBeat(1, 8'h21, 1'b0);
        addBeat(1, 8'h22, 1'b0);
        for (int c = 0; c < 1400 && aborts_seen == 0; c++) runCycles(1);
        checkOutput("tmo_seen", 32'(aborts_seen), 32'd1);
        checkOutput("tmo_lane", 32'(abort_lane), 32'd1);
        checkOutput("tmo_delay", 32'((abort_cycle - last_data_cycle >= TMO) &&
                                     (abort_cycle - last_data_cycle <= TMO + 2)), 32'd1);
        checkOutput("tmo_stat1", statTimeouts(1), 32'd1);
        checkOutput("tmo_stat0", statTimeouts(0), 32'd0);
        checkOutput("tmo_frames1", statFrames(1), 32'd0);
        checkOutput("tmo_delivered", 32'(out_ptr[1]), 32'd2);
        checkOutput("tmo_idle", 32'(status_busy), 32'd0);

        // Long output backpressure mid-frame must not abort.
        applyReset();
        addFrame(0, 5, 8'h31);
        runCycles(4);
        ready_mode    = 2;
        m_axis_tready = 1'b0;
        runCycles(2000);
        checkOutput("bp_busy", 32'(status_busy), 32'd1);
        checkOutput("bp_no_abort", statTimeouts(0), 32'd0);
        checkOutput("bp_partial", 32'(out_ptr[0] < 5), 32'd1);
        ready_mode = 0;
        drain(200);
        checkOutput("bp_frames", statFrames(0), 32'd1);
        checkOutput("bp_aborts", 32'(aborts_seen), 32'd0);

        // Disabling a lane mid-frame lets the frame finish, then excludes it.
        applyReset();
        cfg_header_enable = 1'b0;
        addFrame(0, 4, 8'h41);
        addFrame(0, 2, 8'h51);
        addFrame(1, 2, 8'h61);
        runCycles(3);
        cfg_lane_enable[0] = 1'b0;
        runCycles(40);
        cnt = 0;
        foreach (frame_log[k]) if (frame_log[k] == 0) cnt++;
        checkOutput("en_stat0", statFrames(0), 32'd1);
        checkOutput("en_ptr0", 32'(out_ptr[0]), 32'd4);
        checkOutput("en_lane0_frames", 32'(cnt), 32'd1);
        checkOutput("en_stat1", statFrames(1), 32'd1);
        checkOutput("en_ready0", 32'(s_axis_tready[0]), 32'd0);

        // Asynchronous reset in the middle of a lane-1 frame.
        applyReset();
        addFrame(1, 6, 8'h71);
        runCycles(4);
        checkOutput("mid_busy", 32'(status_busy), 32'd1);
        checkOutput("mid_grant", 32'(status_grant), 32'd1);
        #2;
        clk_core_resn = 1'b0;
        #1;
        checkOutput("async_mvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("async_busy", 32'(status_busy), 32'd0);
        checkOutput("async_grant", 32'(status_grant), 32'd0);
        checkOutput("async_sready", 32'(s_axis_tready), 32'd0);
        applyReset();
        addFrame(0, 2, 8'h91);
        addFrame(2, 2, 8'h81);
        drain(100);
        checkOutput("post_rst_first", 32'(frame_log.size() > 0 ? frame_log[0] : -1), 32'd0);
        checkOutput("post_rst_aborts", 32'(aborts_seen), 32'd0);
        checkOutput("post_rst_tmo1", statTimeouts(1), 32'd0);

        // Randomized traffic with gaps and backpressure.
        for (int it = 0; it < 6; it++) begin
            applyReset();
            cfg_priority_mode = 1'($urandom_range(1));
            cfg_header_enable = 1'($urandom_range(1));
            ready_mode        = 1;
            gap_pct           = 20;
            for (int l = 0; l < LANES; l++) begin
                int nf;
                nf = $urandom_range(1, 3);
                for (int f = 0; f < nf; f++) addRandomFrame(l, $urandom_range(1, 4));
            end
            drain(2000);
            for (int l = 0; l < LANES; l++) begin
                checkOutput("rnd_frames", statFrames(l), 32'(exp_frames[l]));
                checkOutput("rnd_timeouts", statTimeouts(l), 32'd0);
            end
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
